// File: rtl/rv32_pipe_pkg.sv
// Shared decode helpers and encodings for the rv32 pipeline control chain.
package rv32_pipe_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_ACC = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic is_load(input logic [31:0] instr);
        return instr[6:0] == OPC_LOAD;
    endfunction

    // x0 is never a real destination, so rd == 0 counts as no write.
    function automatic logic writes_rd(input logic [31:0] instr);
        logic wr;
        wr = instr[6:0] inside {OPC_LUI, OPC_AUIPC, OPC_JAL,
                                OPC_JALR, OPC_OP, OPC_OP_IMM,
                                OPC_LOAD};
        return wr && (instr[11:7] != 5'd0);
    endfunction

    function automatic logic uses_rs1(input logic [31:0] instr);
        return !(instr[6:0] inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    endfunction

    function automatic logic uses_rs2(input logic [31:0] instr);
        return instr[6:0] inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    endfunction

endpackage

// File: rtl/pipe_hazard_ctl_stage_reg.sv
// One pipeline stage: instruction register plus valid bit.
module pipe_stage_reg
    import rv32_pipe_pkg::*;
#(
    parameter int              ILEN = 32,
    parameter logic [ILEN-1:0] NOP  = ILEN'(NOP_INSTR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bubble,
    input  logic [ILEN-1:0] d,
    input  logic            d_valid,
    output logic [ILEN-1:0] q,
    output logic            valid
);

    // Bubble beats load; neither means hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q     <= NOP;
            valid <= 1'b0;
        end else if (bubble) begin
            q     <= NOP;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= d_valid;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// DE/EXE/ACC/WB control chain with hazard detection,
// forwarding selects and saturating stall/flush counters.
module pipe_hazard_ctl
    import rv32_pipe_pkg::*;
#(
    parameter int              ILEN   = 32,
    parameter bit              FWD_EN = 1'b1,
    parameter logic [ILEN-1:0] NOP    = ILEN'(NOP_INSTR),
    parameter int              CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ILEN-1:0]  instr_if,
    input  logic             if_valid,
    input  logic             br_taken,
    output logic [ILEN-1:0]  instr_de,
    output logic [ILEN-1:0]  instr_exe,
    output logic [ILEN-1:0]  instr_acc,
    output logic [ILEN-1:0]  instr_wb,
    output logic             valid_de,
    output logic             valid_exe,
    output logic             valid_acc,
    output logic             valid_wb,
    output logic             stall_pc,
    output logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             reg_wen,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0] i_de, i_exe, i_acc, i_wb;
    logic        de_rs1, de_rs2;
    logic        exe_wr, acc_wr, wb_wr;
    logic        exe_ld, acc_fwd;
    logic        hit_exe, hit_acc;
    logic        stall;
    logic [ILEN-1:0] de_d;
    fwd_sel_e    fwd_a, fwd_b;

    assign i_de  = instr_de[31:0];
    assign i_exe = instr_exe[31:0];
    assign i_acc = instr_acc[31:0];
    assign i_wb  = instr_wb[31:0];

    assign de_rs1 = valid_de  & uses_rs1(i_de);
    assign de_rs2 = valid_de  & uses_rs2(i_de);
    assign exe_wr = valid_exe & writes_rd(i_exe);
    assign acc_wr = valid_acc & writes_rd(i_acc);
    assign wb_wr  = valid_wb  & writes_rd(i_wb);
    assign exe_ld = is_load(i_exe);
    assign acc_fwd = acc_wr & ~is_load(i_acc);

    assign hit_exe = exe_wr &
        ((de_rs1 & (rs1_of(i_de) == rd_of(i_exe))) |
         (de_rs2 & (rs2_of(i_de) == rd_of(i_exe))));
    assign hit_acc = acc_wr &
        ((de_rs1 & (rs1_of(i_de) == rd_of(i_acc))) |
         (de_rs2 & (rs2_of(i_de) == rd_of(i_acc))));

    // WB is write-through, so only EXE/ACC can block DE.
    assign stall = FWD_EN ? (hit_exe & exe_ld)
                          : (hit_exe | hit_acc);

    assign flush    = br_taken & valid_exe;
    assign stall_pc = stall & ~flush;
    assign reg_wen  = wb_wr;
    assign de_d     = if_valid ? instr_if : NOP;

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN) begin
            if (acc_fwd && rd_of(i_acc) == rs1_of(i_exe))
                fwd_a = FWD_ACC;
            else if (wb_wr && rd_of(i_wb) == rs1_of(i_exe))
                fwd_a = FWD_WB;
            if (acc_fwd && rd_of(i_acc) == rs2_of(i_exe))
                fwd_b = FWD_ACC;
            else if (wb_wr && rd_of(i_wb) == rs2_of(i_exe))
                fwd_b = FWD_WB;
        end
    end

    assign fwd_a_sel = fwd_a;
    assign fwd_b_sel = fwd_b;

    pipe_stage_reg #(.ILEN(ILEN), .NOP(NOP)) u_de (
        .clk     (clk),
        .rst     (rst),
        .load    (~stall),
        .bubble  (flush),
        .d       (de_d),
        .d_valid (if_valid),
        .q       (instr_de),
        .valid   (valid_de)
    );

    pipe_stage_reg #(.ILEN(ILEN), .NOP(NOP)) u_exe (
        .clk     (clk),
        .rst     (rst),
        .load    (1'b1),
        .bubble  (flush | stall),
        .d       (instr_de),
        .d_valid (valid_de),
        .q       (instr_exe),
        .valid   (valid_exe)
    );

    pipe_stage_reg #(.ILEN(ILEN), .NOP(NOP)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .load    (1'b1),
        .bubble  (1'b0),
        .d       (instr_exe),
        .d_valid (valid_exe),
        .q       (instr_acc),
        .valid   (valid_acc)
    );

    pipe_stage_reg #(.ILEN(ILEN), .NOP(NOP)) u_wb (
        .clk     (clk),
        .rst     (rst),
        .load    (1'b1),
        .bubble  (1'b0),
        .d       (instr_acc),
        .d_valid (valid_acc),
        .q       (instr_wb),
        .valid   (valid_wb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl: forwarding, interlock-only
// and narrow-counter instances driven from one stimulus stream.
module tb_pipe_hazard_ctl;

    localparam logic [31:0] I_NOP = 32'h0000_0013;
    localparam logic [31:0] ADD5  = 32'h0020_82B3; // add x5,x1,x2
    localparam logic [31:0] SUB6  = 32'h4032_8333; // sub x6,x5,x3
    localparam logic [31:0] LW7   = 32'h0000_A383; // lw x7,0(x1)
    localparam logic [31:0] ADD8  = 32'h0073_8433; // add x8,x7,x7
    localparam logic [31:0] BEQ   = 32'h0020_8063; // beq x1,x2,0
    localparam logic [31:0] ADDI0 = 32'h0050_0013; // addi x0,x0,5
    localparam logic [31:0] ADD9  = 32'h0000_04B3; // add x9,x0,x0

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_if = I_NOP;
    logic        if_valid = 1'b0;
    logic        br_taken = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] instr_de [3];
    logic [31:0] instr_exe[3];
    logic [31:0] instr_acc[3];
    logic [31:0] instr_wb [3];
    logic        valid_de [3];
    logic        valid_exe[3];
    logic        valid_acc[3];
    logic        valid_wb [3];
    logic        stall_pc [3];
    logic        flush    [3];
    logic [1:0]  fwd_a    [3];
    logic [1:0]  fwd_b    [3];
    logic        reg_wen  [3];
    logic [15:0] scnt     [3];
    logic [15:0] fcnt     [3];
    logic [1:0]  scnt2, fcnt2;

    assign scnt[2] = {14'd0, scnt2};
    assign fcnt[2] = {14'd0, fcnt2};

    pipe_hazard_ctl #(.FWD_EN(1'b1)) dut_fwd (
        .clk(clk), .rst(rst), .instr_if(instr_if),
        .if_valid(if_valid), .br_taken(br_taken),
        .instr_de(instr_de[0]), .instr_exe(instr_exe[0]),
        .instr_acc(instr_acc[0]), .instr_wb(instr_wb[0]),
        .valid_de(valid_de[0]), .valid_exe(valid_exe[0]),
        .valid_acc(valid_acc[0]), .valid_wb(valid_wb[0]),
        .stall_pc(stall_pc[0]), .flush(flush[0]),
        .fwd_a_sel(fwd_a[0]), .fwd_b_sel(fwd_b[0]),
        .reg_wen(reg_wen[0]),
        .stall_cnt(scnt[0]), .flush_cnt(fcnt[0])
    );

    pipe_hazard_ctl #(.FWD_EN(1'b0)) dut_nofwd (
        .clk(clk), .rst(rst), .instr_if(instr_if),
        .if_valid(if_valid), .br_taken(br_taken),
        .instr_de(instr_de[1]), .instr_exe(instr_exe[1]),
        .instr_acc(instr_acc[1]), .instr_wb(instr_wb[1]),
        .valid_de(valid_de[1]), .valid_exe(valid_exe[1]),
        .valid_acc(valid_acc[1]), .valid_wb(valid_wb[1]),
        .stall_pc(stall_pc[1]), .flush(flush[1]),
        .fwd_a_sel(fwd_a[1]), .fwd_b_sel(fwd_b[1]),
        .reg_wen(reg_wen[1]),
        .stall_cnt(scnt[1]), .flush_cnt(fcnt[1])
    );

    pipe_hazard_ctl #(.FWD_EN(1'b1), .CNT_W(2)) dut_cnt2 (
        .clk(clk), .rst(rst), .instr_if(instr_if),
        .if_valid(if_valid), .br_taken(br_taken),
        .instr_de(instr_de[2]), .instr_exe(instr_exe[2]),
        .instr_acc(instr_acc[2]), .instr_wb(instr_wb[2]),
        .valid_de(valid_de[2]), .valid_exe(valid_exe[2]),
        .valid_acc(valid_acc[2]), .valid_wb(valid_wb[2]),
        .stall_pc(stall_pc[2]), .flush(flush[2]),
        .fwd_a_sel(fwd_a[2]), .fwd_b_sel(fwd_b[2]),
        .reg_wen(reg_wen[2]),
        .stall_cnt(scnt2), .flush_cnt(fcnt2)
    );

    typedef struct {
        int          dut;
        bit          rst_first;
        logic [31:0] instr;
        logic        ifv;
        logic        br;
        logic        e_stall;
        logic        e_flush;
        logic [1:0]  e_fa;
        logic [1:0]  e_fb;
        logic        e_wen;
        logic        e_vde;
        logic [31:0] e_exe;
        logic        e_vexe;
        int          e_sc;
        int          e_fc;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(
        int dut, int rf, logic [31:0] ins, int ifv, int br,
        int st, int fl, int fa, int fb, int wen,
        int vde, logic [31:0] exe, int vexe, int sc, int fc
    );
        vec_t v;
        v.dut       = dut;
        v.rst_first = (rf != 0);
        v.instr     = ins;
        v.ifv       = (ifv != 0);
        v.br        = (br != 0);
        v.e_stall   = (st != 0);
        v.e_flush   = (fl != 0);
        v.e_fa      = 2'(fa);
        v.e_fb      = 2'(fb);
        v.e_wen     = (wen != 0);
        v.e_vde     = (vde != 0);
        v.e_exe     = exe;
        v.e_vexe    = (vexe != 0);
        v.e_sc      = sc;
        v.e_fc      = fc;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        instr_if = I_NOP;
        if_valid = 1'b0;
        br_taken = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        int   d;

        // back-to-back ALU, forwarding
        vecs.push_back(mk(0,1,ADD5,1,0, 0,0,0,0,0, 1,I_NOP,0, 0,0));
        vecs.push_back(mk(0,0,SUB6,1,0, 0,0,0,0,0, 1,ADD5,1,  0,0));
        vecs.push_back(mk(0,0,I_NOP,0,0,0,0,0,0,0, 0,SUB6,1,  0,0));
        vecs.push_back(mk(0,0,I_NOP,0,0,0,0,1,0,0, 0,I_NOP,0, 0,0));
        vecs.push_back(mk(0,0,I_NOP,0,0,0,0,0,0,1, 0,I_NOP,0, 0,0));
        // back-to-back ALU, interlock only
        vecs.push_back(mk(1,1,ADD5,1,0, 0,0,0,0,0, 1,I_NOP,0, 0,0));
        vecs.push_back(mk(1,0,SUB6,1,0, 0,0,0,0,0, 1,ADD5,1,  0,0));
        vecs.push_back(mk(1,0,I_NOP,0,0,1,0,0,0,0, 1,I_NOP,0, 1,0));
        vecs.push_back(mk(1,0,I_NOP,0,0,1,0,0,0,0, 1,I_NOP,0, 2,0));
        vecs.push_back(mk(1,0,I_NOP,0,0,0,0,0,0,1, 0,SUB6,1,  2,0));
        vecs.push_back(mk(1,0,I_NOP,0,0,0,0,0,0,0, 0,I_NOP,0, 2,0));
        // load-use
        vecs.push_back(mk(0,1,LW7,1,0,  0,0,0,0,0, 1,I_NOP,0, 0,0));
        vecs.push_back(mk(0,0,ADD8,1,0, 0,0,0,0,0, 1,LW7,1,   0,0));
        vecs.push_back(mk(0,0,I_NOP,0,0,1,0,0,0,0, 1,I_NOP,0, 1,0));
        vecs.push_back(mk(0,0,I_NOP,0,0,0,0,0,0,0, 0,ADD8,1,  1,0));
        vecs.push_back(mk(0,0,I_NOP,0,0,0,0,2,2,1, 0,I_NOP,0, 1,0));
        // taken branch
        vecs.push_back(mk(0,1,BEQ,1,0,  0,0,0,0,0, 1,I_NOP,0, 0,0));
        vecs.push_back(mk(0,0,ADD8,1,0, 0,0,0,0,0, 1,BEQ,1,   0,0));
        vecs.push_back(mk(0,0,ADD5,1,1, 0,1,0,0,0, 0,I_NOP,0, 0,1));
        vecs.push_back(mk(0,0,I_NOP,0,0,0,0,0,0,0, 0,I_NOP,0, 0,1));
        // flush and load-use stall together
        vecs.push_back(mk(0,1,LW7,1,0,  0,0,0,0,0, 1,I_NOP,0, 0,0));
        vecs.push_back(mk(0,0,ADD8,1,0, 0,0,0,0,0, 1,LW7,1,   0,0));
        vecs.push_back(mk(0,0,I_NOP,0,1,0,1,0,0,0, 0,I_NOP,0, 0,1));
        vecs.push_back(mk(0,0,I_NOP,0,0,0,0,0,0,0, 0,I_NOP,0, 0,1));
        // x0 destination
        vecs.push_back(mk(0,1,ADDI0,1,0,0,0,0,0,0, 1,I_NOP,0, 0,0));
        vecs.push_back(mk(0,0,ADD9,1,0, 0,0,0,0,0, 1,ADDI0,1, 0,0));
        vecs.push_back(mk(0,0,I_NOP,0,0,0,0,0,0,0, 0,ADD9,1,  0,0));
        vecs.push_back(mk(0,0,I_NOP,0,0,0,0,0,0,0, 0,I_NOP,0, 0,0));
        vecs.push_back(mk(0,0,I_NOP,0,0,0,0,0,0,0, 0,I_NOP,0, 0,0));

        foreach (vecs[i]) begin
            v = vecs[i];
            d = v.dut;
            if (v.rst_first)
                do_reset();
            instr_if = v.instr;
            if_valid = v.ifv;
            br_taken = v.br;
            #1;
            chk($sformatf("v%0d stall_pc", i),
                32'(stall_pc[d]), 32'(v.e_stall));
            chk($sformatf("v%0d flush", i),
                32'(flush[d]), 32'(v.e_flush));
            chk($sformatf("v%0d fwd_a", i),
                32'(fwd_a[d]), 32'(v.e_fa));
            chk($sformatf("v%0d fwd_b", i),
                32'(fwd_b[d]), 32'(v.e_fb));
            chk($sformatf("v%0d reg_wen", i),
                32'(reg_wen[d]), 32'(v.e_wen));
            step();
            chk($sformatf("v%0d valid_de", i),
                32'(valid_de[d]), 32'(v.e_vde));
            chk($sformatf("v%0d instr_exe", i),
                instr_exe[d], v.e_exe);
            chk($sformatf("v%0d valid_exe", i),
                32'(valid_exe[d]), 32'(v.e_vexe));
            chk($sformatf("v%0d stall_cnt", i),
                32'(scnt[d]), v.e_sc);
            chk($sformatf("v%0d flush_cnt", i),
                32'(fcnt[d]), v.e_fc);
        end

        // five load-use events against a 2-bit counter
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            instr_if = LW7;
            if_valid = 1'b1;
            step();
            instr_if = ADD8;
            step();
            instr_if = I_NOP;
            if_valid = 1'b0;
            #1;
            chk($sformatf("sat%0d stall_pc", k),
                32'(stall_pc[2]), 32'd1);
            step();
            chk($sformatf("sat%0d stall_cnt", k),
                32'(scnt[2]), (k < 3) ? k : 3);
            step();
        end
        chk("sat fwd stall_cnt", 32'(scnt[0]), 32'd5);

        // asynchronous reset mid-stream, then normal first edge
        instr_if = ADD5;
        if_valid = 1'b1;
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst instr_de",  instr_de[0],  I_NOP);
        chk("arst instr_exe", instr_exe[0], I_NOP);
        chk("arst instr_acc", instr_acc[0], I_NOP);
        chk("arst instr_wb",  instr_wb[0],  I_NOP);
        chk("arst valids", 32'({valid_de[0], valid_exe[0],
                                valid_acc[0], valid_wb[0]}), 32'd0);
        chk("arst stall_cnt", 32'(scnt[0]), 32'd0);
        chk("arst stall_cnt2", 32'(scnt[2]), 32'd0);
        chk("arst comb", 32'({stall_pc[0], flush[0], fwd_a[0],
                              fwd_b[0], reg_wen[0]}), 32'd0);
        rst = 1'b1;
        step();
        chk("rel instr_de",  instr_de[0], ADD5);
        chk("rel valid_de",  32'(valid_de[0]), 32'd1);
        chk("rel valid_exe", 32'(valid_exe[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
